// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with synchronizer, debounce and one-pulse key events.
//
// Parameters:
//   SCAN_DIV       - clk cycles each row is driven; columns sampled on the last one (4..65535)
//   DEBOUNCE_CNT   - consecutive matching samples to accept a press or a release (1..255)
//   REPEAT_SAMPLES - held-key samples between auto-repeat pulses (KEYPAD_REPEAT_EN only)
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   col      - column inputs, pulled up, active-low, asynchronous to clk
//   row      - row drive, active-low, exactly one bit low
//   keyValid - one-cycle pulse per accepted key event
//   keyValue - code of the last accepted key, stable between pulses
//
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.

module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_CNT   = 10,
  parameter int unsigned REPEAT_SAMPLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       keyValid,
  output logic [3:0] keyValue
);

  if (SCAN_DIV < 4 || SCAN_DIV > 65535 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 255 ||
      REPEAT_SAMPLES < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DebLast = 8'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHold, StRelease} state_e;

  state_e      state_q, state_d;
  logic [15:0] div_q;
  logic        sample;
  logic [3:0]  col_s1_q, col_s2_q;
  logic [1:0]  row_idx_q, row_idx_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [3:0]  value_q, value_d;
  logic        key_low;
  logic [1:0]  first_col;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RepLast = 16'(REPEAT_SAMPLES - 1);
  logic [15:0] rep_q, rep_d;
`endif

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    case ({r, c})
      4'b00_00: v = 4'h1;
      4'b00_01: v = 4'h2;
      4'b00_10: v = 4'h3;
      4'b00_11: v = 4'hA;
      4'b01_00: v = 4'h4;
      4'b01_01: v = 4'h5;
      4'b01_10: v = 4'h6;
      4'b01_11: v = 4'hB;
      4'b10_00: v = 4'h7;
      4'b10_01: v = 4'h8;
      4'b10_10: v = 4'h9;
      4'b10_11: v = 4'hC;
      4'b11_00: v = 4'hE;
      4'b11_01: v = 4'h0;
      4'b11_10: v = 4'hF;
      default:  v = 4'hD;
    endcase
    return v;
  endfunction

  // Dwell counter runs in every state so sample timing never depends on the FSM.
  assign sample = (div_q == DivLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (sample) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col;
      col_s2_q <= col_s1_q;
    end
  end

  assign key_low = ~col_s2_q[col_idx_q];

  always_comb begin
    first_col = 2'd3;
    if (!col_s2_q[0])      first_col = 2'd0;
    else if (!col_s2_q[1]) first_col = 2'd1;
    else if (!col_s2_q[2]) first_col = 2'd2;
  end

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    value_d   = value_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = (state_q == StHold) ? rep_q : '0;
`endif
    if (sample) begin
      unique case (state_q)
        StScan: begin
          if (col_s2_q != 4'hF) begin
            col_idx_d = first_col;
            cnt_d     = '0;
            state_d   = StDebounce;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        StDebounce: begin
          if (key_low) begin
            if (cnt_q == DebLast) begin
              valid_d = 1'b1;
              value_d = key_map(row_idx_q, col_idx_q);
              cnt_d   = '0;
              state_d = StHold;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d     = '0;
            row_idx_d = 2'd0;
            state_d   = StScan;
          end
        end
        StHold: begin
          // The sample that first sees the key high is the first release match.
          if (!key_low) begin
            if (DebLast == 8'd0) begin
              cnt_d     = '0;
              row_idx_d = 2'd0;
              state_d   = StScan;
            end else begin
              cnt_d   = 8'd1;
              state_d = StRelease;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q == RepLast) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + 16'd1;
            end
`else
            // Held key produces no further pulses.
`endif
          end
        end
        StRelease: begin
          if (!key_low) begin
            if (cnt_q == DebLast) begin
              cnt_d     = '0;
              row_idx_d = 2'd0;
              state_d   = StScan;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            cnt_d   = '0;
            state_d = StHold;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StScan;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      value_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign row      = ~(4'b0001 << row_idx_q);
  assign keyValid = valid_q;
  assign keyValue = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_SAMPLES=5).
// A keypad matrix model drives col from row; expected key codes are queued when a
// press is applied and popped whenever keyValid pulses.

module tb_keypad_scanner;

  localparam int unsigned Div = 4;

  logic       clk;
  logic       reset;
  logic [3:0] col;
  logic [3:0] row;
  logic       keyValid;
  logic [3:0] keyValue;

  logic [3:0] pressed [4];
  logic [3:0] exp_q [$];
  int         tests;
  int         fails;
  int unsigned div;
  logic       prev_valid;

  keypad_scanner #(
    .SCAN_DIV      (4),
    .DEBOUNCE_CNT  (3),
    .REPEAT_SAMPLES(5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .col     (col),
    .row     (row),
    .keyValid(keyValid),
    .keyValue(keyValue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed switch connects its row line to its column line.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~pressed[r];
    end
  end

  // Reference dwell phase; 0 at a negedge means a sample edge just occurred.
  always @(posedge clk or negedge reset) begin
    if (!reset) div <= 0;
    else        div <= (div == Div - 1) ? 0 : div + 1;
  end

  // Scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (keyValid) begin
      tests++;
      if (prev_valid === 1'b1) begin
        fails++;
        $display("FAIL consecutive_valid: keyValid high two cycles in a row, required single pulse");
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: keyValid with keyValue=%h, required no pulse", keyValue);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (keyValue !== e) begin
          fails++;
          $display("FAIL key_value: keyValue=%h, required %h", keyValue, e);
        end
      end
    end
    prev_valid = keyValid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_samples(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (div != 0) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      wait_samples(1);
      k++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    repeat (3) @(negedge clk);
    tests++;
    if (row !== 4'b1110) begin
      fails++;
      $display("FAIL reset_row: row=%b required 1110", row);
    end
    tests++;
    if (keyValid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: keyValid=%b required 0", keyValid);
    end
    tests++;
    if (keyValue !== 4'h0) begin
      fails++;
      $display("FAIL reset_value: keyValue=%h required 0", keyValue);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (row !== 4'b1110 || keyValid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: row=%b keyValid=%b required 1110/0", row, keyValid);
    end
  endtask

  task automatic test_scan_walk();
    logic [3:0] seq [4];
    do_reset();
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      wait_samples(1);
      tests++;
      if (row !== seq[i % 4]) begin
        fails++;
        $display("FAIL scan_walk[%0d]: row=%b required %b", i, row, seq[i % 4]);
      end
    end
  endtask

  task automatic test_clean_7();
    do_reset();
    exp_q.push_back(4'h7);
    pressed[2] = 4'b0001;
    wait_drain(12);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL key7_pulse: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    wait_samples(10);
    tests++;
    if (row !== 4'b1011 || keyValue !== 4'h7) begin
      fails++;
      $display("FAIL key7_hold: row=%b keyValue=%h required 1011/7", row, keyValue);
    end
    pressed[2] = 4'h0;
    wait_samples(2);
    tests++;
    if (row !== 4'b1011) begin
      fails++;
      $display("FAIL key7_release2: row=%b required 1011", row);
    end
    wait_samples(1);
    tests++;
    if (row !== 4'b1110) begin
      fails++;
      $display("FAIL key7_release3: row=%b required 1110", row);
    end
    wait_samples(6);
    tests++;
    if (keyValue !== 4'h7) begin
      fails++;
      $display("FAIL key7_stable: keyValue=%h required 7", keyValue);
    end
  endtask

  task automatic test_bounce_hash();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pressed[3] = (i % 2 == 1) ? 4'b0100 : 4'h0;
      wait_samples(1);
    end
    exp_q.push_back(4'hF);
    pressed[3] = 4'b0100;
    wait_drain(12);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL hash_pulse: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (row !== 4'b0111) begin
      fails++;
      $display("FAIL hash_frozen: row=%b required 0111", row);
    end
    pressed[3] = 4'h0;
    wait_samples(3);
    tests++;
    if (row !== 4'b1110) begin
      fails++;
      $display("FAIL hash_release: row=%b required 1110", row);
    end
  endtask

  task automatic test_multi_5();
    do_reset();
    exp_q.push_back(4'h5);
    pressed[1] = 4'b1010;
    wait_drain(12);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL multi5_pulse: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    pressed[3] = 4'b1000;
    wait_samples(10);
    tests++;
    if (row !== 4'b1101 || keyValue !== 4'h5) begin
      fails++;
      $display("FAIL multi5_ignore_d: row=%b keyValue=%h required 1101/5", row, keyValue);
    end
    pressed[1] = 4'h0;
    pressed[3] = 4'h0;
    wait_samples(2);
    tests++;
    if (row !== 4'b1101) begin
      fails++;
      $display("FAIL multi5_release2: row=%b required 1101", row);
    end
    wait_samples(1);
    tests++;
    if (row !== 4'b1110) begin
      fails++;
      $display("FAIL multi5_release3: row=%b required 1110", row);
    end
    wait_samples(4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    pressed[0] = 4'b0010;
    wait_samples(2);
    reset = 1'b0;
    #1;
    tests++;
    if (row !== 4'b1110 || keyValid !== 1'b0 || keyValue !== 4'h0) begin
      fails++;
      $display("FAIL mid_reset: row=%b keyValid=%b keyValue=%h required 1110/0/0",
               row, keyValid, keyValue);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(4'h2);
    wait_samples(3);
    tests++;
    if (exp_q.size() != 1) begin
      fails++;
      $display("FAIL mid_reset_early: pending=%0d required 1", exp_q.size());
    end
    wait_samples(1);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL mid_reset_pulse: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    pressed[0] = 4'h0;
    wait_samples(5);
  endtask

  task automatic test_repeat_a();
    do_reset();
    pressed[0] = 4'b1000;
    exp_q.push_back(4'hA);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 0; i < 3; i++) exp_q.push_back(4'hA);
`endif
    wait_samples(20);
    pressed[0] = 4'h0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL repeat_a: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    wait_samples(6);
    tests++;
    if (keyValue !== 4'hA) begin
      fails++;
      $display("FAIL repeat_a_value: keyValue=%h required a", keyValue);
    end
  endtask

  task automatic test_release_bounce_9();
    do_reset();
    exp_q.push_back(4'h9);
    pressed[2] = 4'b0100;
    wait_drain(12);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL key9_pulse: pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    wait_samples(3);
    pressed[2] = 4'h0;
    wait_samples(1);
    pressed[2] = 4'b0100;
    wait_samples(1);
    tests++;
    if (row !== 4'b1011) begin
      fails++;
      $display("FAIL key9_rehold: row=%b required 1011", row);
    end
    pressed[2] = 4'h0;
    wait_samples(2);
    tests++;
    if (row !== 4'b1011) begin
      fails++;
      $display("FAIL key9_release2: row=%b required 1011", row);
    end
    wait_samples(1);
    tests++;
    if (row !== 4'b1110) begin
      fails++;
      $display("FAIL key9_release3: row=%b required 1110", row);
    end
    wait_samples(4);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    prev_valid = 1'b0;
    reset      = 1'b0;
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    test_reset();
    test_scan_walk();
    test_clean_7();
    test_bounce_hash();
    test_multi_5();
    test_reset_mid();
    test_repeat_a();
    test_release_bounce_9();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL final_queue: pending=%0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
